hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Parametrised hazard/stall controller for the pipelined CPU; sits beside the ID stage.
//  Detects RAW hazards against N_WB in-flight writer stages (optional forwarding mode), holds fetch
//  for a counted branch-resolution window, and interlocks ID behind a multi-cycle mul/div op.
//  Drives IF/ID stall, EX bubble and IF flush; keeps a saturating stall-cycle counter.
// PARAMETERS
//  REG_W      5  register-address width; address 0 is hardwired zero and never hazards
//  N_WB       3  writer stages checked; index 0 = EX, 1 = MEM, ... N_WB-1 = WB
//  BR_PENALTY 2  max cycles fetch is held after a branch leaves ID (>=1)
//  MD_LAT     4  cycles a mul/div op occupies the unit (>=1)
//  FWD_EN     0  0: any writer-stage match stalls; 1: only a load in stage 0 stalls
//  CNT_W      16 stall-cycle counter width
// PORTS
//  clk         in  1           rising-edge clock
//  rst_n       in  1           synchronous reset, active low
//  id_valid    in  1           valid instruction in ID
//  id_rs       in  REG_W       ID source register rs
//  id_rt       in  REG_W       ID source register rt
//  id_use_rs   in  1           ID instruction reads rs
//  id_use_rt   in  1           ID instruction reads rt
//  id_branch   in  1           ID instruction is beq/bne/bgtz
//  id_md       in  1           ID instruction is mul/div
//  wr_en       in  N_WB        per-stage RegWr
//  wr_rw       in  N_WB*REG_W  per-stage destination, stage j at [j*REG_W +: REG_W]
//  wr_load     in  N_WB        per-stage instruction is a load
//  br_resolved in  1           EX reports branch outcome this cycle
//  br_taken    in  1           outcome, qualified by br_resolved
//  if_stall    out 1           hold PC and IF/ID register
//  id_stall    out 1           hold ID
//  ex_bubble   out 1           inject nop into ID/EX
//  if_flush    out 1           squash IF/ID contents
//  md_busy     out 1           mul/div unit occupied
//  stall_cnt   out CNT_W       saturating count of cycles with if_stall=1
// BEHAVIOUR
//  Reset: all registered state cleared on rising clk while rst_n=0: FSM=IDLE, counters 0,
//   stall_cnt 0; all outputs 0 during and after reset. Reset mid-branch/mid-mul/div abandons it.
//  Match j (comb): id_valid & wr_en[j] & wr_rw_j!=0 & ((id_use_rs & rs==wr_rw_j) | (id_use_rt & rt==wr_rw_j)).
//  dhaz: FWD_EN=0 -> OR of match over all j; FWD_EN=1 -> match_0 & wr_load[0].
//  FSM states IDLE, BR_WAIT, MD_BUSY; down-counter cnt (width fits max(BR_PENALTY,MD_LAT)).
//   IDLE: id_branch & id_valid & !dhaz -> BR_WAIT, cnt=BR_PENALTY-1.
//         id_md & id_valid & !dhaz -> MD_BUSY, cnt=MD_LAT-1. (branch and md exclusive by decode)
//   BR_WAIT: br_resolved or cnt==0 -> IDLE; else cnt--. if_flush=br_resolved&br_taken (1-cycle pulse).
//   MD_BUSY: cnt==0 -> IDLE; else cnt--. A new id_md is accepted only after returning to IDLE.
//  id_stall = dhaz | (state==MD_BUSY & id_valid). ex_bubble = id_stall.
//  if_stall = id_stall | state==BR_WAIT. md_busy = state==MD_BUSY. All outputs combinational from
//   state+inputs (0-cycle latency); state updates on the next clk edge.
//  Stalled branch/md (dhaz=1) does not leave IDLE; it issues the cycle dhaz clears.
//  br_resolved outside BR_WAIT: ignored, if_flush=0.
//  br_resolved in the cycle cnt==0: one if_flush pulse if taken, then IDLE.
//  stall_cnt += 1 each cycle if_stall=1; holds at all-ones (no wrap).
// TESTING
//  FWD_EN=0: wr_en=3'b100, wr_rw[WB]=7, id_rs=7, use_rs -> id_stall=if_stall=ex_bubble=1; rs=0 variant -> all 0.
//  FWD_EN=1: EX match rw=9 non-load -> no stall; set wr_load[0]=1 -> stall exactly while asserted.
//  Branch, BR_PENALTY=2, no resolve -> if_stall 2 cycles then 0; resolve taken in cycle 1 -> if_flush 1 cycle, IDLE next.
//  id_md, MD_LAT=4, id_valid held -> md_busy & id_stall 4 cycles, then a second id_md issues.
//  rst_n=0 for 1 cycle mid MD_BUSY -> next cycle md_busy=0, stall_cnt=0, outputs 0.
//  CNT_W=4, hold dhaz 20 cycles -> stall_cnt saturates at 15, no wrap.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard/stall controller beside the ID stage. It detects RAW
//               hazards against N_WB in-flight writer stages, with an optional
//               forwarding mode. It holds fetch for a bounded branch-resolution
//               window and interlocks ID behind a multi-cycle mul/div op. It
//               also keeps a saturating count of IF stall cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   synchronous reset, active low
//   id_valid_i     in   valid instruction in ID
//   id_rs_i/rt_i   in   ID source register addresses
//   id_use_rs_i/rt in   ID instruction reads rs / rt
//   id_branch_i    in   ID instruction is a conditional branch
//   id_md_i        in   ID instruction is mul/div
//   wr_en_i        in   per-stage RegWr (index 0 = EX ... N_WB-1 = WB)
//   wr_rw_i        in   per-stage destination, stage j at [j*REG_W +: REG_W]
//   wr_load_i      in   per-stage instruction is a load
//   br_resolved_i  in   EX reports the branch outcome this cycle
//   br_taken_i     in   outcome, qualified by br_resolved_i
//   if_stall_o     out  hold PC and IF/ID register
//   id_stall_o     out  hold ID
//   ex_bubble_o    out  inject nop into ID/EX
//   if_flush_o     out  squash IF/ID contents
//   md_busy_o      out  mul/div unit occupied
//   stall_cnt_o    out  saturating count of cycles with if_stall_o=1
// ============================================================================
module hazard_ctrl #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned N_WB       = 3,
    parameter int unsigned BR_PENALTY = 2,
    parameter int unsigned MD_LAT     = 4,
    parameter int unsigned FWD_EN     = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid_i,
    input  logic [REG_W-1:0]        id_rs_i,
    input  logic [REG_W-1:0]        id_rt_i,
    input  logic                    id_use_rs_i,
    input  logic                    id_use_rt_i,
    input  logic                    id_branch_i,
    input  logic                    id_md_i,
    input  logic [N_WB-1:0]         wr_en_i,
    input  logic [N_WB*REG_W-1:0]   wr_rw_i,
    input  logic [N_WB-1:0]         wr_load_i,
    input  logic                    br_resolved_i,
    input  logic                    br_taken_i,
    output logic                    if_stall_o,
    output logic                    id_stall_o,
    output logic                    ex_bubble_o,
    output logic                    if_flush_o,
    output logic                    md_busy_o,
    output logic [CNT_W-1:0]        stall_cnt_o
);

    localparam int unsigned c_cnt_max = (BR_PENALTY > MD_LAT) ? BR_PENALTY : MD_LAT;
    localparam int unsigned c_cnt_w   = $clog2(c_cnt_max + 1);

    typedef logic [c_cnt_w-1:0] cnt_t;

    localparam cnt_t c_br_load = cnt_t'(BR_PENALTY - 1);
    localparam cnt_t c_md_load = cnt_t'(MD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BR_WAIT = 2'd1,
        MD_BUSY = 2'd2
    } state_t;

    state_t           state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [N_WB-1:0]  w_match;
    logic             w_dhaz;
    logic             w_flush;
    logic             w_id_stall;
    logic             w_if_stall;
    logic             w_unused;

    // Per-stage RAW match; register 0 is hardwired zero and never hazards.
    for (genvar j = 0; j < N_WB; j++) begin : g_match
        logic [REG_W-1:0] w_rw;
        assign w_rw       = wr_rw_i[j*REG_W +: REG_W];
        assign w_match[j] = id_valid_i & wr_en_i[j] & (w_rw != '0) &
                            ((id_use_rs_i & (id_rs_i == w_rw)) |
                             (id_use_rt_i & (id_rt_i == w_rw)));
    end

    // With forwarding, only a load still in EX cannot be bypassed in time.
    if (FWD_EN == 0) begin : g_nofwd
        assign w_dhaz = |w_match;
    end else begin : g_fwd
        assign w_dhaz = w_match[0] & wr_load_i[0];
    end

    // Inputs not consumed in every configuration.
    assign w_unused = ^{wr_load_i, w_match};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_flush = 1'b0;
        case (state_q)
            IDLE: begin
                // A hazarded branch/md stays in ID and issues once dhaz clears.
                if (id_valid_i && !w_dhaz) begin
                    if (id_branch_i) begin
                        state_d = BR_WAIT;
                        cnt_d   = c_br_load;
                    end else if (id_md_i) begin
                        state_d = MD_BUSY;
                        cnt_d   = c_md_load;
                    end
                end
            end
            BR_WAIT: begin
                w_flush = br_resolved_i & br_taken_i;
                if (br_resolved_i || (cnt_q == '0)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted.
    assign w_id_stall = rst_n & (w_dhaz | ((state_q == MD_BUSY) & id_valid_i));
    assign w_if_stall = w_id_stall | (rst_n & (state_q == BR_WAIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_if_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign id_stall_o  = w_id_stall;
    assign ex_bubble_o = w_id_stall;
    assign if_stall_o  = w_if_stall;
    assign if_flush_o  = rst_n & w_flush;
    assign md_busy_o   = rst_n & (state_q == MD_BUSY);
    assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire
